// File: rtl/antenna_key_encoder_if.sv
// rtl/antenna_key_encoder_if.sv - key/code bus between front panel logic and antenna key encoder
// Purpose: bundles the key encoder's functional inputs and outputs.
// Signals:
//   I_key[5:0]       raw asynchronous key lines, bit n = antenna n+1
//   I_clear          one-cycle deselect request
//   I_other_bcd[2:0] code held by the other radio port
//   O_bcd[2:0]       committed antenna code (0 = none, 1..6)
//   O_valid          one-cycle pulse, O_bcd written this cycle
//   O_reject         one-cycle pulse, debounced press refused
// Modports: master drives the inputs (panel/bench side), slave is the encoder.
interface antenna_key_encoder_if;
    logic [5:0] I_key;
    logic       I_clear;
    logic [2:0] I_other_bcd;
    logic [2:0] O_bcd;
    logic       O_valid;
    logic       O_reject;

    modport master (
        output I_key,
        output I_clear,
        output I_other_bcd,
        input  O_bcd,
        input  O_valid,
        input  O_reject
    );

    modport slave (
        input  I_key,
        input  I_clear,
        input  I_other_bcd,
        output O_bcd,
        output O_valid,
        output O_reject
    );
endinterface

// File: rtl/antenna_key_encoder.sv
// rtl/antenna_key_encoder.sv - debounced six-key to 3-bit antenna code encoder for one radio port
// Purpose: synchronises and debounces six raw key lines, commits a single pressed key as
//   antenna code 1..6, refuses multi-key presses, and emits one-cycle strobes on every
//   commit, clear and refusal.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset
//   bus  antenna_key_encoder_if.slave (I_key, I_clear, I_other_bcd in; O_bcd, O_valid, O_reject out)
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles needed to accept a press or a release (>= 2)
// Build option:
//   ANT_INTERLOCK_EN  when defined, a single-key commit equal to the non-zero I_other_bcd
//                     is refused with O_reject; otherwise I_other_bcd is ignored.
module antenna_key_encoder #(
    parameter  int DEBOUNCE_CYCLES = 50000,
    localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    antenna_key_encoder_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DEBOUNCE = 2'd1,
        S_HELD     = 2'd2
    } state_t;

    logic [5:0]       key_meta_q, key_meta_d;
    logic [5:0]       key_s_q,    key_s_d;
    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [5:0]       snap_q,     snap_d;
    logic [2:0]       bcd_q,      bcd_d;
    logic             valid_q,    valid_d;
    logic             reject_q,   reject_d;

    logic       evaluate;
    logic       snap_one_hot;
    logic [2:0] snap_code;
    logic       interlock_hit;

    // Code of the snapshot; only meaningful when exactly one bit is set.
    always_comb begin
        snap_code = 3'd0;
        for (int i = 0; i < 6; i++) begin
            if (snap_q[i]) begin
                snap_code = 3'(i + 1);
            end
        end
        snap_one_hot = (snap_q != 6'd0) && ((snap_q & (snap_q - 6'd1)) == 6'd0);
    end

`ifdef ANT_INTERLOCK_EN
    // The other radio port already owns this antenna.
    assign interlock_hit = (bus.I_other_bcd != 3'd0) && (bus.I_other_bcd == snap_code);
`else
    logic unused_other_bcd;
    assign unused_other_bcd = ^bus.I_other_bcd;
    assign interlock_hit    = 1'b0;
`endif

    always_comb begin
        key_meta_d = bus.I_key;
        key_s_d    = key_meta_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        bcd_d      = bcd_q;
        valid_d    = 1'b0;
        reject_d   = 1'b0;
        evaluate   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (key_s_q != 6'd0) begin
                    state_d = S_DEBOUNCE;
                    snap_d  = key_s_q;
                    cnt_d   = '0;
                end
            end
            S_DEBOUNCE: begin
                if (key_s_q == 6'd0) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (key_s_q != snap_q) begin
                    // Key pattern changed mid-debounce: restart on the new pattern.
                    snap_d = key_s_q;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    evaluate = 1'b1;
                    state_d  = S_HELD;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HELD: begin
                // Any key activity restarts the release window; nothing commits here.
                if (key_s_q != 6'd0) begin
                    cnt_d = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (evaluate) begin
            if (snap_one_hot && !interlock_hit) begin
                bcd_d   = snap_code;
                valid_d = 1'b1;
            end else begin
                reject_d = 1'b1;
            end
        end

        // Clear overrides any coincident commit or refusal; FSM and counter carry on.
        if (bus.I_clear) begin
            bcd_d    = 3'd0;
            valid_d  = 1'b1;
            reject_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_meta_q <= 6'd0;
            key_s_q    <= 6'd0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            snap_q     <= 6'd0;
            bcd_q      <= 3'd0;
            valid_q    <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            key_meta_q <= key_meta_d;
            key_s_q    <= key_s_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            reject_q   <= reject_d;
        end
    end

    assign bus.O_bcd    = bcd_q;
    assign bus.O_valid  = valid_q;
    assign bus.O_reject = reject_q;

endmodule

// File: tb/tb_antenna_key_encoder.sv
// tb/tb_antenna_key_encoder.sv - self-checking bench for antenna_key_encoder with DEBOUNCE_CYCLES=4
module tb_antenna_key_encoder;

    localparam int DEB = 4;
    localparam int LAT = DEB + 3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    antenna_key_encoder_if bus ();

    antenna_key_encoder #(.DEBOUNCE_CYCLES(DEB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [5:0] key;
        logic [2:0] other;
        logic [2:0] exp_bcd;
        logic       exp_valid;
        logic       exp_reject;
    } vec_t;

    typedef struct {
        logic [2:0] bcd;
        logic       valid;
        logic       reject;
        int         at_cyc;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard: every strobe must match the oldest expected record.
    always @(negedge clk) begin
        if (!rst && (bus.O_valid || bus.O_reject)) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_strobe: got bcd=%0d valid=%0b reject=%0b at cycle %0d expected no strobe",
                         bus.O_bcd, bus.O_valid, bus.O_reject, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("strobe_outputs", {27'd0, bus.O_bcd, bus.O_valid, bus.O_reject},
                      {27'd0, e.bcd, e.valid, e.reject});
                check("strobe_cycle", cyc, e.at_cyc);
            end
        end
    end

    vec_t vecs[9];

    initial begin
        vecs[0] = '{6'b000100, 3'd0, 3'd3, 1'b1, 1'b0};
        vecs[1] = '{6'b010010, 3'd0, 3'd3, 1'b0, 1'b1};
        vecs[2] = '{6'b100000, 3'd0, 3'd6, 1'b1, 1'b0};
        vecs[3] = '{6'b100000, 3'd0, 3'd6, 1'b1, 1'b0};
        vecs[4] = '{6'b000001, 3'd0, 3'd1, 1'b1, 1'b0};
        vecs[5] = '{6'b111111, 3'd0, 3'd1, 1'b0, 1'b1};
        vecs[6] = '{6'b001000, 3'd5, 3'd4, 1'b1, 1'b0};
`ifdef ANT_INTERLOCK_EN
        vecs[7] = '{6'b010000, 3'd5, 3'd4, 1'b0, 1'b1};
`else
        vecs[7] = '{6'b010000, 3'd5, 3'd5, 1'b1, 1'b0};
`endif
        vecs[8] = '{6'b000010, 3'd0, 3'd2, 1'b1, 1'b0};

        // Reset held with all keys pressed.
        rst = 1'b1;
        bus.I_key = 6'h3F;
        bus.I_clear = 1'b0;
        bus.I_other_bcd = 3'd0;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check($sformatf("reset_hold%0d", i), {29'd0, bus.O_bcd, bus.O_valid, bus.O_reject}, 32'd0);
        end
        rst = 1'b0;
        tick(1);
        check("reset_release", {29'd0, bus.O_bcd, bus.O_valid, bus.O_reject}, 32'd0);
        bus.I_key = 6'd0;
        tick(12);

        // Table-driven press / hold / release vectors.
        for (int i = 0; i < 9; i++) begin
            bus.I_key = vecs[i].key;
            bus.I_other_bcd = vecs[i].other;
            sb.push_back('{vecs[i].exp_bcd, vecs[i].exp_valid, vecs[i].exp_reject, cyc + LAT});
            tick(20);
            bus.I_key = 6'd0;
            tick(12);
            bus.I_other_bcd = 3'd0;
            check($sformatf("vec%0d_bcd_after", i), {29'd0, bus.O_bcd}, {29'd0, vecs[i].exp_bcd});
        end

        // Reset in the middle of a debounce: no strobe, code cleared.
        bus.I_key = 6'b001000;
        tick(4);
        rst = 1'b1;
        bus.I_key = 6'd0;
        tick(2);
        rst = 1'b0;
        tick(15);
        check("reset_midop_bcd", {29'd0, bus.O_bcd}, 32'd0);

        // Bouncing key[0]: no strobe while bouncing, commit once stable.
        for (int i = 0; i < 10; i++) begin
            bus.I_key = (i % 2 == 0) ? 6'b000001 : 6'b000000;
            tick(2);
        end
        bus.I_key = 6'b000001;
        sb.push_back('{3'd1, 1'b1, 1'b0, cyc + LAT});
        tick(20);
        check("bounce_bcd", {29'd0, bus.O_bcd}, 32'd1);
        bus.I_key = 6'd0;
        tick(12);

        // Clear in the exact commit cycle of key[1]: clear wins.
        bus.I_key = 6'b000010;
        sb.push_back('{3'd0, 1'b1, 1'b0, cyc + LAT});
        tick(LAT - 1);
        bus.I_clear = 1'b1;
        tick(1);
        bus.I_clear = 1'b0;
        tick(13);
        check("clear_commit_bcd", {29'd0, bus.O_bcd}, 32'd0);
        bus.I_key = 6'd0;
        tick(12);

        // Standalone clear after a commit.
        bus.I_key = 6'b100000;
        sb.push_back('{3'd6, 1'b1, 1'b0, cyc + LAT});
        tick(20);
        bus.I_key = 6'd0;
        tick(12);
        check("pre_clear_bcd", {29'd0, bus.O_bcd}, 32'd6);
        bus.I_clear = 1'b1;
        sb.push_back('{3'd0, 1'b1, 1'b0, cyc + 1});
        tick(1);
        bus.I_clear = 1'b0;
        tick(3);
        check("clear_bcd", {29'd0, bus.O_bcd}, 32'd0);

        tick(5);
        check("scoreboard_empty", sb.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
